f_adder: RTL and testbench
==========================

# f_adder

Registered ripple-carry full adder. Adds two WIDTH-bit operands plus a carry-in and presents the sum and carry-out on registered outputs one clock after sampling. At WIDTH=1 it is the single-bit full-adder cell that the wider adder blocks in the design are built from and checked against.

## Interface
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits of a + b + cin.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- Arithmetic: {cout, sum} = a + b + cin, computed at WIDTH+1 bits; no truncation before the carry is taken.
- Per-bit structure: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])); c[0] = cin; cout = c[WIDTH].
- Combinational result is captured into the sum and cout registers on every rising clk edge. There is no enable: the registers load on every edge.
- Operands are unsigned. No overflow flag. Signed users derive overflow externally from the MSBs.
- Unknown (X/Z) inputs are not masked. They propagate to the outputs.

## Timing
- Latency: 1 clk from input sample edge to valid outputs (2 clk with F_ADDER_IN_REG_EN). Throughput: one result per cycle.
- Outputs change only on rising clk edges. There is no combinational path from any input to any output.
- Reset: when rst_n is low at a rising edge, sum is 0 and cout is 0 after that edge. Any input-stage registers also clear to 0. Inputs are ignored during that edge.
- Reset mid-operation: any in-flight result is discarded. The first valid result is produced from inputs sampled at the first edge with rst_n high, and appears after the normal latency.
- Reset value of every output: sum = 0, cout = 0.
- Simultaneous reset and input change: reset wins.
- Wrap-around: a = b = all ones with cin = 1 gives sum = all ones and cout = 1.

## Configuration
- F_ADDER_IN_REG_EN
  - Defined: a, b and cin pass through an extra input register stage before the adder. Latency is 2 clk. These registers also reset synchronously to 0.
  - Undefined: inputs feed the adder directly. Latency is 1 clk.
  - Arithmetic is identical in both builds.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with a = b = cin = 1 at WIDTH = 1 -> sum = 0, cout = 0 after each edge.
- Exhaustive 1-bit check at WIDTH = 1, 10 ns clock: apply (a, b, cin) = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle -> (cout, sum) one cycle later = 00, 01, 01, 10, 01, 10, 10, 11.
- Wide carry ripple at WIDTH = 8: a = 0xFF, b = 0x00, cin = 1 -> sum = 0x00, cout = 1. Then a = 0x80, b = 0x80, cin = 0 -> sum = 0x00, cout = 1.
- Back-to-back throughput at WIDTH = 8: a = 0x12, b = 0x34, cin = 0 then a = 0xF0, b = 0x0F, cin = 1 on consecutive edges -> 0x46/0 then 0x00/1 on consecutive cycles.
- Mid-stream reset: assert rst_n = 0 for one edge between two operations -> outputs 0/0 for that cycle, and the next result is correct at the normal latency.
- With F_ADDER_IN_REG_EN defined, repeat the exhaustive 1-bit check -> identical results, each delayed by 2 clk.

Source files
------------

// File: rtl/f_adder.sv
// ============================================================================
// Module   : f_adder
// Purpose  : Registered ripple-carry full adder, {cout, sum} = a + b + cin.
//            Define F_ADDER_IN_REG_EN to add an input register stage
//            (latency 2 clk instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

`ifdef F_ADDER_IN_REG_EN
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= a;
            r_b   <= b;
            r_cin <= cin;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = a;
    assign w_b   = b;
    assign w_cin = cin;
`endif

    assign w_c[0] = w_cin;

    // Explicit per-bit cells so the 1-bit instance is the reference cell itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_p;
        assign w_p      = w_a[i] ^ w_b[i];
        assign w_s[i]   = w_p ^ w_c[i];
        assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & w_p);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= w_s;
            cout <= w_c[WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_f_adder.sv
// ============================================================================
// Module   : tb_f_adder
// Purpose  : Directed-vector bench for f_adder at WIDTH=1 and WIDTH=8.
//            Honours F_ADDER_IN_REG_EN for the expected latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f_adder;

`ifdef F_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, cin1, s1, co1;
    logic [7:0] a8, b8, s8;
    logic       cin8, co8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f_adder #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .sum  (s1),
        .cout (co1)
    );

    f_adder #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (s8),
        .cout (co8)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 1-bit truth table, indexed by {a,b,cin}; value is {cout,sum}
    logic [1:0] exp1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // 8-bit vectors, applied back-to-back; expected value is {cout,sum}
    logic [7:0] va   [6] = '{8'hFF, 8'h80, 8'h12, 8'hF0, 8'hFF, 8'h55};
    logic [7:0] vb   [6] = '{8'h00, 8'h80, 8'h34, 8'h0F, 8'hFF, 8'h2A};
    logic       vc   [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [8:0] vexp [6] = '{9'h100, 9'h100, 9'h046, 9'h100, 9'h1FF, 9'h07F};

    initial begin
        logic [2:0] v;

        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset1_%0d", i), {14'd0, co1, s1}, 16'h0000);
            check($sformatf("reset8_%0d", i), {7'd0, co8, s8}, 16'h0000);
        end
        rst_n = 1'b1;

        // Exhaustive 1-bit sweep, one vector per cycle
        for (int t = 0; t < 8 + LAT - 1; t++) begin
            if (t < 8) begin
                v = t[2:0];
                {a1, b1, cin1} = v;
            end
            tick();
            if (t >= LAT - 1)
                check($sformatf("bit1_%0d", t - LAT + 1), {14'd0, co1, s1},
                      {14'd0, exp1[t - LAT + 1]});
        end

        // 8-bit carry ripple, wrap-around and back-to-back throughput
        for (int t = 0; t < 6 + LAT - 1; t++) begin
            if (t < 6) begin
                a8 = va[t]; b8 = vb[t]; cin8 = vc[t];
            end
            tick();
            if (t >= LAT - 1)
                check($sformatf("add8_%0d", t - LAT + 1), {7'd0, co8, s8},
                      {7'd0, vexp[t - LAT + 1]});
        end

        // Mid-stream reset: flush pipeline with a known op, then reset one edge
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        check("pre_rst8", {7'd0, co8, s8}, 16'h0046);

        rst_n = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        check("mid_rst8", {7'd0, co8, s8}, 16'h0000);

        rst_n = 1'b1;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check($sformatf("post_rst_fill_%0d", i), {7'd0, co8, s8}, 16'h0000);
        end
        tick();
        check("post_rst8", {7'd0, co8, s8}, 16'h0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
